acc_processor_top: RTL and testbench

- Top level of an 8-bit accumulator-based processor.
- Contains a 16-word internal program ROM, a 16-byte data RAM, PC, a 2-stage pipeline (fetch -> execute), an 8-bit ACC and carry/zero/overflow flag registers, plus a single maskable interrupt.
- ACC and flags are exported for observation.
- Sits as the design root; no external bus.

---
 rtl/acc_processor_top.sv | 185 ++++++++++++++++++
 tb/tb_acc_processor_top.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/acc_processor_top.sv
// 8-bit accumulator processor: 16-word program ROM, 16-byte RAM, fetch -> execute pipeline.
// Define ACC_INTERRUPT_EN to build the maskable interrupt, IE flag, saved PC and RETI.
module acc_processor_top #(
   parameter logic [3:0] IVEC = 4'hE
) (
   input  logic       clk,
   input  logic       StartEverything,
   input  logic       secondstagereset,
   input  logic       interrupt,
   output logic [7:0] ACCout,
   output logic       coutRegout,
   output logic       zeroRegout,
   output logic       overflowRegout
);
   localparam int DATA_W = 8;
   localparam logic [11:0] NOP_WORD = 12'h000;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LDA = 4'h2, OP_STA = 4'h3,
      OP_ADDI = 4'h4, OP_ADD = 4'h5, OP_SUBI = 4'h6, OP_ANDI = 4'h7,
      OP_ORI = 4'h8, OP_XORI = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
      OP_JMP = 4'hC, OP_JZ = 4'hD, OP_JC = 4'hE, OP_SYS = 4'hF
   } op_t;

   function automatic logic [11:0] rom_word(input logic [3:0] a);
      case (a)
         4'h0:    rom_word = 12'h105;
         4'h1:    rom_word = 12'h47D;
         4'h2:    rom_word = 12'h47E;
         4'h3:    rom_word = 12'h300;
         4'h4:    rom_word = 12'h601;
         4'h5:    rom_word = 12'hC05;
         4'hE:    rom_word = 12'h1AA;
         4'hF:    rom_word = 12'hF01;
         default: rom_word = NOP_WORD;
      endcase
   endfunction

   function automatic logic [DATA_W:0] add_carry(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                 input logic cin);
      add_carry = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
   endfunction

   function automatic logic add_ovf(input logic signed [DATA_W-1:0] a, input logic signed [DATA_W-1:0] b,
                                    input logic signed [DATA_W-1:0] r);
      add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
   endfunction

   logic [3:0]        pc_p0;
   logic [11:0]       ir_p1;
   logic [DATA_W-1:0] acc, acc_n;
   logic              c_flag, z_flag, v_flag, c_n, z_n, v_n;
   logic [DATA_W-1:0] ram [16];
   logic [DATA_W-1:0] opnd, ram_rd, x_op;
   logic [DATA_W:0]   sum;
   logic [3:0]        addr, pc_n;
   logic [11:0]       ir_n;
   logic              acc_wr, ram_we, jump, halt, reti;
   op_t               op;

   assign op     = op_t'(ir_p1[11:8]);
   assign opnd   = ir_p1[7:0];
   assign addr   = ir_p1[3:0];
   assign ram_rd = ram[addr];

   // ---- execute stage (p1): ALU, flags, branch resolution ----
   always_comb begin
      acc_n  = acc;
      c_n    = c_flag;
      v_n    = v_flag;
      acc_wr = 1'b0;
      ram_we = 1'b0;
      jump   = 1'b0;
      halt   = 1'b0;
      reti   = 1'b0;
      x_op   = (op == OP_ADD) ? ram_rd : (op == OP_SUBI) ? ~opnd : opnd;
      sum    = add_carry(acc, x_op, op == OP_SUBI);
      case (op)
         OP_LDI:  begin acc_n = opnd;   acc_wr = 1'b1; end
         OP_LDA:  begin acc_n = ram_rd; acc_wr = 1'b1; end
         OP_STA:  ram_we = 1'b1;
         OP_ADDI, OP_ADD, OP_SUBI: begin
            {c_n, acc_n} = sum;
            v_n    = add_ovf(acc, x_op, sum[DATA_W-1:0]);
            acc_wr = 1'b1;
         end
         OP_ANDI: begin acc_n = acc & opnd; acc_wr = 1'b1; end
         OP_ORI:  begin acc_n = acc | opnd; acc_wr = 1'b1; end
         OP_XORI: begin acc_n = acc ^ opnd; acc_wr = 1'b1; end
         OP_SHL:  begin c_n = acc[DATA_W-1]; acc_n = {acc[DATA_W-2:0], 1'b0}; acc_wr = 1'b1; end
         OP_SHR:  begin c_n = acc[0]; acc_n = {1'b0, acc[DATA_W-1:1]}; acc_wr = 1'b1; end
         OP_JMP:  jump = 1'b1;
         OP_JZ:   jump = z_flag;
         OP_JC:   jump = c_flag;
         OP_SYS: begin
            if (opnd[0]) begin
`ifdef ACC_INTERRUPT_EN
               reti = 1'b1;
`endif
            end else begin
               halt = 1'b1;
            end
         end
         default: ;
      endcase
      z_n = acc_wr ? (acc_n == '0) : z_flag;
   end

`ifdef ACC_INTERRUPT_EN
   logic       ie, ie_n;
   logic [3:0] saved_pc, saved_n;
`else
   logic unused_irq;
   assign unused_irq = interrupt ^ reti;
`endif

   // ---- fetch stage (p0): next PC / IR, bubbles and vectoring ----
   always_comb begin
      pc_n = pc_p0 + 4'd1;
      ir_n = rom_word(pc_p0);
      if (jump) begin
         pc_n = addr;
         ir_n = NOP_WORD;
      end else if (halt) begin
         pc_n = pc_p0;
         ir_n = ir_p1;
      end
`ifdef ACC_INTERRUPT_EN
      ie_n    = ie;
      saved_n = saved_pc;
      if (reti) begin
         pc_n = saved_pc;
         ir_n = NOP_WORD;
         ie_n = 1'b1;
      end
      if (interrupt && ie) begin
         saved_n = jump ? addr : pc_p0 - 4'd1;
         pc_n    = IVEC;
         ir_n    = NOP_WORD;
         ie_n    = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (StartEverything) begin
         pc_p0  <= '0;
         ir_p1  <= NOP_WORD;
         acc    <= '0;
         c_flag <= 1'b0;
         z_flag <= 1'b0;
         v_flag <= 1'b0;
`ifdef ACC_INTERRUPT_EN
         ie       <= 1'b1;
         saved_pc <= '0;
`endif
      end else if (secondstagereset) begin
         // flush squashes the execute stage; interrupt waits a cycle
         pc_p0 <= pc_p0 + 4'd1;
         ir_p1 <= NOP_WORD;
      end else begin
         pc_p0  <= pc_n;
         ir_p1  <= ir_n;
         acc    <= acc_n;
         c_flag <= c_n;
         z_flag <= z_n;
         v_flag <= v_n;
`ifdef ACC_INTERRUPT_EN
         ie       <= ie_n;
         saved_pc <= saved_n;
`endif
      end
   end

   // RAM contents survive reset
   always_ff @(posedge clk) begin
      if (!StartEverything && !secondstagereset && ram_we)
         ram[addr] <= acc;
   end

   assign ACCout         = acc;
   assign coutRegout     = c_flag;
   assign zeroRegout     = z_flag;
   assign overflowRegout = v_flag;
endmodule

// File: tb/tb_acc_processor_top.sv
// Directed bench for acc_processor_top: vector table over the default program plus
// hand sequences for interrupt entry/return (ACC_INTERRUPT_EN) and reset priority.
module tb_acc_processor_top;
   logic       clk = 1'b0;
   logic       rst = 1'b1, ssr = 1'b0, irq = 1'b0;
   logic [7:0] acc;
   logic       c, z, v;
   int         checks = 0, errors = 0;
   logic       force_irq = 1'b0;

   acc_processor_top dut (
      .clk(clk), .StartEverything(rst), .secondstagereset(ssr), .interrupt(irq),
      .ACCout(acc), .coutRegout(c), .zeroRegout(z), .overflowRegout(v)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, ssr, irq;
      logic [7:0] acc;
      logic       c, z, v;
      logic [3:0] pc;
   } vec_t;

   vec_t tbl [23];

   task automatic step(input logic r, input logic s, input logic i);
      @(negedge clk);
      rst = r; ssr = s; irq = i;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] ea, input logic ec, input logic ez,
                        input logic ev, input logic [3:0] epc);
      checks++;
      if ({acc, c, z, v, dut.pc_p0} !== {ea, ec, ez, ev, epc}) begin
         errors++;
         $display("FAIL %s: acc=%h c=%b z=%b v=%b pc=%h, expected acc=%h c=%b z=%b v=%b pc=%h",
                  name, acc, c, z, v, dut.pc_p0, ea, ec, ez, ev, epc);
      end
   endtask

   task automatic check_bit(input string name, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic run_table(input string tag);
      for (int k = 0; k < 23; k++) begin
         step(tbl[k].rst, tbl[k].ssr, tbl[k].irq | (force_irq & ~tbl[k].rst));
         check($sformatf("%s row %0d", tag, k), tbl[k].acc, tbl[k].c, tbl[k].z, tbl[k].v, tbl[k].pc);
      end
   endtask

   initial begin
      // default program from reset
      tbl[0]  = '{1,0,0, 8'h00,0,0,0, 4'h0};
      tbl[1]  = '{0,0,0, 8'h00,0,0,0, 4'h1};
      tbl[2]  = '{0,0,0, 8'h05,0,0,0, 4'h2};
      tbl[3]  = '{0,0,0, 8'h82,0,0,1, 4'h3};
      tbl[4]  = '{0,0,0, 8'h00,1,1,0, 4'h4};
      tbl[5]  = '{0,0,0, 8'h00,1,1,0, 4'h5};
      tbl[6]  = '{0,0,0, 8'hFF,0,0,0, 4'h6};
      tbl[7]  = '{0,0,0, 8'hFF,0,0,0, 4'h5};
      tbl[8]  = '{0,0,0, 8'hFF,0,0,0, 4'h6};
      tbl[9]  = '{0,0,0, 8'hFF,0,0,0, 4'h5};
      // reset with flush and interrupt, then flush while IR holds ADDI 7D
      tbl[10] = '{1,1,1, 8'h00,0,0,0, 4'h0};
      tbl[11] = '{0,0,0, 8'h00,0,0,0, 4'h1};
      tbl[12] = '{0,0,0, 8'h05,0,0,0, 4'h2};
      tbl[13] = '{0,1,0, 8'h05,0,0,0, 4'h3};
      tbl[14] = '{0,0,0, 8'h05,0,0,0, 4'h4};
      tbl[15] = '{0,0,0, 8'h05,0,0,0, 4'h5};
      tbl[16] = '{0,0,0, 8'h04,1,0,0, 4'h6};
      tbl[17] = '{0,0,0, 8'h04,1,0,0, 4'h5};
      tbl[18] = '{0,0,0, 8'h04,1,0,0, 4'h6};
      // plain mid-program reset restarts from address 0
      tbl[19] = '{1,0,0, 8'h00,0,0,0, 4'h0};
      tbl[20] = '{0,0,0, 8'h00,0,0,0, 4'h1};
      tbl[21] = '{0,0,0, 8'h05,0,0,0, 4'h2};
      tbl[22] = '{0,0,0, 8'h82,0,0,1, 4'h3};

      run_table("base");
      checks++;
      if (dut.ram[0] !== 8'h05) begin
         errors++;
         $display("FAIL sta_ram0: got %h, expected 05", dut.ram[0]);
      end

`ifdef ACC_INTERRUPT_EN
      // reset beats flush and interrupt; IE ends up set
      step(1, 1, 1);
      check("rst_all", 8'h00, 0, 0, 0, 4'h0);
      check_bit("rst_ie", {3'b0, dut.ie}, 4'h1);
      step(1, 0, 0);
      for (int k = 0; k < 10; k++) step(0, 0, 0);
      check("spin", 8'hFF, 0, 0, 0, 4'h6);
      // request while IR holds the taken JMP 5: return address is the jump target
      step(0, 0, 1);
      check("vec_jmp", 8'hFF, 0, 0, 0, 4'hE);
      check_bit("ie_cleared", {3'b0, dut.ie}, 4'h0);
      check_bit("saved_jmp", dut.saved_pc, 4'h5);
      step(0, 0, 1);
      check("isr_fetch", 8'hFF, 0, 0, 0, 4'hF);
      step(0, 0, 1);
      check("isr_ldi", 8'hAA, 0, 0, 0, 4'h0);
      step(0, 0, 1);
      check("reti", 8'hAA, 0, 0, 0, 4'h5);
      check_bit("ie_restored", {3'b0, dut.ie}, 4'h1);
      step(0, 0, 0);
      step(0, 0, 0);
      check("spin_nop", 8'hAA, 0, 0, 0, 4'h5);
      // request with a NOP in IR: return to PC-1, which re-runs SUBI
      step(0, 0, 1);
      check("vec_nop", 8'hAA, 0, 0, 0, 4'hE);
      check_bit("saved_nop", dut.saved_pc, 4'h4);
      step(0, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      check("reti2", 8'hAA, 0, 0, 0, 4'h4);
      step(0, 0, 0);
      step(0, 0, 0);
      check("subi_after", 8'hA9, 1, 0, 0, 4'h6);
      // flush coinciding with a request defers the interrupt one cycle
      step(0, 1, 1);
      check("defer", 8'hA9, 1, 0, 0, 4'h7);
      step(0, 0, 1);
      check("deferred_vec", 8'hA9, 1, 0, 0, 4'hE);
`else
      // interrupt input has no effect when the feature is absent
      force_irq = 1'b1;
      run_table("irq_hi");
      force_irq = 1'b0;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end
endmodule
